// File: rtl/hamming_scrub_ctrl_if.sv
// Datapath-facing signals of the scrub sequencer: counter enable out, capture/check status back in.
interface hamming_scrub_ctrl_if #(
    parameter int unsigned PARITY_BITS = 12
);
    logic                   cnt_enable;
    logic                   busy;
    logic                   error_detected;
    logic [PARITY_BITS-1:0] syndrome;

    modport master (
        output cnt_enable,
        input  busy,
        input  error_detected,
        input  syndrome
    );

    modport slave (
        input  cnt_enable,
        output busy,
        output error_detected,
        output syndrome
    );
endinterface

// File: rtl/hamming_scrub_ctrl.sv
// Periodic scrub sequencer for the Hamming-protected counter: freezes the counter for parity
// capture/check, holds it while the correction loads back, and keeps error statistics.
module hamming_scrub_ctrl #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned BLOCKS       = WIDTH / 4,
    parameter int unsigned PARITY_BITS  = BLOCKS * 3,
    parameter int unsigned PERIOD_W     = 16,
    parameter int unsigned CORR_HOLD    = 2,
    parameter int unsigned BUSY_TIMEOUT = 8,
    parameter int unsigned ERRCNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic [PERIOD_W-1:0]         scrub_period,
    input  logic                        force_scrub,
    input  logic                        clr_stats,
    hamming_scrub_ctrl_if.master        dp,
    output logic                        scrub_active,
    output logic                        scrub_done,
    output logic                        err_flag,
    output logic [ERRCNT_W-1:0]         err_count,
    output logic [BLOCKS-1:0]           blk_err_mask,
    output logic                        timeout_err
);

    localparam int unsigned HOLD_MAX = (BUSY_TIMEOUT > CORR_HOLD) ? BUSY_TIMEOUT : CORR_HOLD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFreeze,
        StWaitBusy,
        StCheck,
        StCorrect,
        StResume
    } state_e;

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   period_cnt_q, period_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
    logic [BLOCKS-1:0]     blk_err_mask_q, blk_err_mask_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  err_flag_q, err_flag_d;
    logic [BLOCKS-1:0]     syn_mask;
    logic                  period_hit;

    always_comb begin
        syn_mask = '0;
        for (int unsigned b = 0; b < BLOCKS; b++) begin
            syn_mask[b] = |dp.syndrome[b*3 +: 3];
        end
    end

    // A new scrub_period only matters when the running count equals it minus one.
    assign period_hit = (scrub_period != '0) &&
                        (period_cnt_q == (scrub_period - PERIOD_W'(1)));

    always_comb begin
        state_d        = state_q;
        period_cnt_d   = period_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        err_count_d    = err_count_q;
        blk_err_mask_d = blk_err_mask_q;
        timeout_err_d  = timeout_err_q;
        err_flag_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                period_cnt_d = period_cnt_q + PERIOD_W'(1);
                if (!run) begin
                    state_d      = StIdle;
                    period_cnt_d = '0;
                end else if (force_scrub || period_hit) begin
                    state_d      = StFreeze;
                    period_cnt_d = '0;
                end
            end
            StFreeze: begin
                state_d    = StWaitBusy;
                hold_cnt_d = '0;
            end
            StWaitBusy: begin
                if (dp.busy) begin
                    state_d = StCheck;
                end else if (hold_cnt_q == HOLD_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StResume;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            StCheck: begin
                if (dp.error_detected) begin
                    blk_err_mask_d = syn_mask;
                    err_flag_d     = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERRCNT_W'(1);
                    end
                    hold_cnt_d = '0;
                    state_d    = StCorrect;
                end else begin
                    state_d = StResume;
                end
            end
            StCorrect: begin
                if (hold_cnt_q == HOLD_W'(CORR_HOLD - 1)) begin
                    state_d = StResume;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            StResume: begin
                state_d = run ? StRun : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clr_stats) begin
            err_count_d    = '0;
            timeout_err_d  = 1'b0;
            blk_err_mask_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            period_cnt_q   <= '0;
            hold_cnt_q     <= '0;
            err_count_q    <= '0;
            blk_err_mask_q <= '0;
            timeout_err_q  <= 1'b0;
            err_flag_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_cnt_q   <= period_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            err_count_q    <= err_count_d;
            blk_err_mask_q <= blk_err_mask_d;
            timeout_err_q  <= timeout_err_d;
            err_flag_q     <= err_flag_d;
        end
    end

    // Decoded from the state register so the datapath sees a clean, glitch-free enable.
    assign dp.cnt_enable  = (state_q == StRun);
    assign scrub_active   = (state_q == StFreeze) || (state_q == StWaitBusy) ||
                            (state_q == StCheck)  || (state_q == StCorrect);
    assign scrub_done     = (state_q == StResume);
    assign err_flag       = err_flag_q;
    assign err_count      = err_count_q;
    assign blk_err_mask   = blk_err_mask_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Scoreboard bench for hamming_scrub_ctrl: stimulus queues expected per-scrub results,
// a monitor checks each one when scrub_done pulses.
module tb_hamming_scrub_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] scrub_period;
    logic        force_scrub;
    logic        clr_stats;
    logic        scrub_active;
    logic        scrub_done;
    logic        err_flag;
    logic [7:0]  err_count;
    logic [3:0]  blk_err_mask;
    logic        timeout_err;

    hamming_scrub_ctrl_if #(.PARITY_BITS(12)) dp_if ();

    hamming_scrub_ctrl #(
        .WIDTH        (16),
        .PERIOD_W     (16),
        .CORR_HOLD    (2),
        .BUSY_TIMEOUT (8),
        .ERRCNT_W     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .scrub_period (scrub_period),
        .force_scrub  (force_scrub),
        .clr_stats    (clr_stats),
        .dp           (dp_if),
        .scrub_active (scrub_active),
        .scrub_done   (scrub_done),
        .err_flag     (err_flag),
        .err_count    (err_count),
        .blk_err_mask (blk_err_mask),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp_run;  // enabled cycles before FREEZE, -1 = don't care
        int lat;      // FREEZE to scrub_done
        int ef;       // err_flag pulses during the scrub
        int cnt;
        int mask;
        int to;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        busy_en = 1'b1;
    logic        err_en  = 1'b0;
    logic [11:0] syn_val = 12'h030;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Datapath stand-in: busy rises one cycle after enable falls, error reported with it.
    initial begin
        logic act_prev;
        act_prev = 1'b0;
        dp_if.busy = 1'b0;
        dp_if.error_detected = 1'b0;
        dp_if.syndrome = '0;
        forever begin
            @(posedge clk);
            #1;
            dp_if.busy           = busy_en && scrub_active && act_prev;
            dp_if.error_detected = err_en && dp_if.busy;
            dp_if.syndrome       = err_en ? syn_val : 12'h000;
            act_prev             = scrub_active;
        end
    end

    // Monitor: measures each scrub and checks it against the queued expectation.
    initial begin
        int   run_len;
        int   last_run;
        int   lat;
        int   ef;
        bit   in_scrub;
        exp_t e;
        run_len = 0; last_run = 0; lat = 0; ef = 0; in_scrub = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_scrub = 1'b0; run_len = 0; lat = 0; ef = 0;
            end else begin
                if (dp_if.cnt_enable) begin
                    run_len++;
                end else begin
                    if (scrub_active && !in_scrub) begin
                        in_scrub = 1'b1; last_run = run_len; lat = 0; ef = 0;
                    end else if (in_scrub) begin
                        lat++;
                    end
                    run_len = 0;
                end
                if (err_flag) ef++;
                if (scrub_done) begin
                    chk("done_inside_scrub", int'(in_scrub), 1);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_scrub_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.exp_run >= 0) chk("sb_run_len", last_run, e.exp_run);
                        chk("sb_latency", lat, e.lat);
                        chk("sb_err_flag_pulses", ef, e.ef);
                        chk("sb_err_count", int'(err_count), e.cnt);
                        chk("sb_blk_err_mask", int'(blk_err_mask), e.mask);
                        chk("sb_timeout_err", int'(timeout_err), e.to);
                    end
                    in_scrub = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int r, input int l, input int f, input int c, input int m,
                        input int t);
        exp_t e;
        e.exp_run = r; e.lat = l; e.ef = f; e.cnt = c; e.mask = m; e.to = t;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int max);
        int i = 0;
        while (sb_q.size() != 0 && i < max) begin
            cyc(1);
            i++;
        end
        chk("drain_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic wait_run();
        int i = 0;
        while (!dp_if.cnt_enable && i < 50) begin
            cyc(1);
            i++;
        end
        chk("run_ready", int'(dp_if.cnt_enable), 1);
    endtask

    // Pulse force_scrub from RUN; optionally clear stats in CHECK or drop run in CORRECT.
    task automatic do_force(input bit clr_at_check, input bit run_off_in_correct);
        wait_run();
        force_scrub = 1'b1;
        cyc(1);
        force_scrub = 1'b0;  // FREEZE
        cyc(2);              // CHECK when busy answers on time
        if (clr_at_check) clr_stats = 1'b1;
        cyc(1);
        clr_stats = 1'b0;
        if (run_off_in_correct) run = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int drops;
        reset = 1'b0; run = 1'b1; scrub_period = 16'd0; force_scrub = 1'b0; clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt_enable", int'(dp_if.cnt_enable), 0);
        chk("rst_scrub_active", int'(scrub_active), 0);
        chk("rst_scrub_done", int'(scrub_done), 0);
        chk("rst_err_flag", int'(err_flag), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_blk_err_mask", int'(blk_err_mask), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);

        // Reset then run with periodic scrubbing disabled.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_cycle1_enable", int'(dp_if.cnt_enable), 0);
        @(posedge clk);
        #1;
        chk("release_cycle2_enable", int'(dp_if.cnt_enable), 1);
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (!dp_if.cnt_enable || scrub_active) drops++;
        end
        chk("run_enable_drops", drops, 0);
        chk("run_err_count", int'(err_count), 0);
        chk("run_timeout_err", int'(timeout_err), 0);

        // Periodic clean scrubs, period 10, started from a zeroed period counter.
        run = 1'b0;
        cyc(1);
        scrub_period = 16'd10;
        run = 1'b1;
        for (int i = 0; i < 3; i++) push(10, 3, 0, 0, 0, 0);
        wait_drain(200);
        scrub_period = 16'd0;

        // Injected error: syndrome 0x030 flags block 1.
        err_en = 1'b1;
        push(-1, 5, 1, 1, 4'b0010, 0);
        do_force(1'b0, 1'b0);
        wait_drain(100);
        err_en = 1'b0;

        // Busy timeout: 8 WAIT_BUSY cycles, no CHECK.
        busy_en = 1'b0;
        push(-1, 9, 0, 1, 4'b0010, 1);
        do_force(1'b0, 1'b0);
        wait_drain(100);
        busy_en = 1'b1;
        cyc(2);
        chk("timeout_resumes_run", int'(dp_if.cnt_enable), 1);
        clr_stats = 1'b1;
        cyc(1);
        clr_stats = 1'b0;
        chk("clr_timeout_err", int'(timeout_err), 0);
        chk("clr_err_count", int'(err_count), 0);
        chk("clr_blk_err_mask", int'(blk_err_mask), 0);

        // Saturation over 300 errored scrubs, then clear colliding with an increment.
        err_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push(-1, 5, 1, (i + 1 > 255) ? 255 : i + 1, 4'b0010, 0);
            do_force(1'b0, 1'b0);
            wait_drain(100);
        end
        chk("sat_err_count", int'(err_count), 255);
        push(-1, 5, 1, 0, 0, 0);
        do_force(1'b1, 1'b0);
        wait_drain(100);
        chk("clr_wins_err_count", int'(err_count), 0);

        // run dropped during CORRECT: scrub completes, then IDLE.
        push(-1, 5, 1, 1, 4'b0010, 0);
        do_force(1'b0, 1'b1);
        wait_drain(100);
        cyc(2);
        chk("idle_after_run_off_enable", int'(dp_if.cnt_enable), 0);
        chk("idle_after_run_off_active", int'(scrub_active), 0);

        // Asynchronous reset while waiting for busy.
        err_en = 1'b0;
        busy_en = 1'b0;
        run = 1'b1;
        wait_run();
        force_scrub = 1'b1;
        cyc(1);
        force_scrub = 1'b0;
        cyc(1);
        chk("pre_reset_active", int'(scrub_active), 1);
        chk("pre_reset_err_count", int'(err_count), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_cnt_enable", int'(dp_if.cnt_enable), 0);
        chk("midrst_scrub_active", int'(scrub_active), 0);
        chk("midrst_err_count", int'(err_count), 0);
        chk("midrst_blk_err_mask", int'(blk_err_mask), 0);
        chk("midrst_timeout_err", int'(timeout_err), 0);
        @(negedge clk);
        reset = 1'b1;
        busy_en = 1'b1;
        cyc(3);
        chk("leftover_expectations", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
